regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_REQ writeback sources (e.g. ALU, LSU, CSR unit) using round-robin arbitration with a valid/ready handshake.
- Grants at most one request per cycle. The granted write is registered and drives the register file's wr_en/wr_addr/wr_data one cycle later.
- Exports the in-flight write so decode can bypass it, and keeps a saturating contention counter for performance analysis.

---
 rtl/rv_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 62 ++++++
 tb/tb_regfile_wb_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file widths and the hard-wired zero register index.
package rv_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0] xlen_t;
  localparam reg_addr_t REG_ZERO = 5'd0;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_grant
);
  logic [IW-1:0] j;
  // Walk offsets from farthest to nearest so the nearest valid request wins.
  always_comb begin
    grant = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        grant_idx = j;
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the register-file write port among writeback sources.
module regfile_wb_arbiter
  import rv_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = XLEN,
  parameter int CNT_W = 16,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [GW-1:0]             grant_id,
  output logic [CNT_W-1:0]          contention_cnt
);
  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];
  logic [NUM_REQ-1:0] grant;
  logic [GW-1:0] rr_ptr, g;
  logic any_grant, transfer, multi;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
    assign data_a[i] = req_data[i*DATA_W +: DATA_W];
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .grant_idx(g),
    .any_grant(any_grant)
  );
  assign req_ready = reset ? '0 : grant;
  assign transfer = any_grant && !reset;
  assign multi = $countones(req_valid) > 1;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      grant_id <= '0;
      contention_cnt <= '0;
      rr_ptr <= '0;
    end else begin
      // x0 writes are consumed but never reach the register file.
      wr_en <= transfer && (addr_a[g] != ADDR_W'(REG_ZERO));
      if (transfer) begin
        wr_addr <= addr_a[g];
        wr_data <= data_a[g];
        grant_id <= g;
        rr_ptr <= (g == GW'(NUM_REQ - 1)) ? '0 : g + GW'(1);
      end
      if (multi && !(&contention_cnt)) contention_cnt <= contention_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of grant order, write latency, x0 discard and counter saturation.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic [2:0] req_valid, req_ready;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic wr_en;
  logic [4:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0] grant_id;
  logic [3:0] contention_cnt;
  int total = 0;
  int bad = 0;
  regfile_wb_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32), .CNT_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .grant_id(grant_id),
    .contention_cnt(contention_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  // A pending request must stay valid with stable payload until it transfers.
  logic [2:0] pv, pr;
  logic [14:0] pa;
  logic [95:0] pd;
  logic prst = 1'b1;
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (!prst && !reset && pv[i] && !pr[i])
        assert (req_valid[i] && req_addr[i*5 +: 5] == pa[i*5 +: 5] && req_data[i*32 +: 32] == pd[i*32 +: 32])
          else $error("requester %0d dropped or changed a pending request", i);
    pv <= req_valid;
    pr <= req_ready;
    pa <= req_addr;
    pd <= req_data;
    prst <= reset;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic sample;
    @(negedge clk);
  endtask
  task automatic drive(input logic [2:0] v, input logic [4:0] a0, a1, a2, input logic [31:0] d0, d1, d2);
    req_valid = v;
    req_addr = {a2, a1, a0};
    req_data = {d2, d1, d0};
  endtask
  task automatic do_reset;
    reset = 1'b1;
    req_valid = '0;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    drive(3'b111, 5'd5, 5'd6, 5'd7, 32'h100, 32'h200, 32'h300);
    repeat (2) begin
      sample();
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_wr_en", 32'(wr_en), 32'h0);
      chk("rst_cnt", 32'(contention_cnt), 32'h0);
      tick();
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      sample();
      chk("rr_ready", 32'(req_ready), 32'(3'b001 << (k % 3)));
      chk("rr_cnt", 32'(contention_cnt), 32'(k));
      if (k == 0) chk("rr_wr_en0", 32'(wr_en), 32'h0);
      else begin
        chk("rr_wr_en", 32'(wr_en), 32'h1);
        chk("rr_wr_addr", 32'(wr_addr), 32'(5 + (k - 1) % 3));
        chk("rr_grant_id", 32'(grant_id), 32'((k - 1) % 3));
        chk("rr_wr_data", wr_data, 32'h100 * 32'((k - 1) % 3 + 1));
      end
      tick();
    end
    do_reset();
    drive(3'b010, 5'd0, 5'd1, 5'd0, 32'h0, 32'hbeefdead, 32'h0);
    sample();
    chk("single_ready", 32'(req_ready), 32'b010);
    chk("single_cnt", 32'(contention_cnt), 32'h0);
    tick();
    req_valid = '0;
    sample();
    chk("single_wr_en", 32'(wr_en), 32'h1);
    chk("single_wr_addr", 32'(wr_addr), 32'h1);
    chk("single_wr_data", wr_data, 32'hbeefdead);
    chk("single_grant_id", 32'(grant_id), 32'h1);
    chk("idle_ready", 32'(req_ready), 32'h0);
    tick();
    sample();
    chk("pulse_wr_en", 32'(wr_en), 32'h0);
    chk("hold_wr_addr", 32'(wr_addr), 32'h1);
    tick();
    drive(3'b001, 5'd0, 5'd0, 5'd0, 32'hdeadbeef, 32'h0, 32'h0);
    sample();
    chk("x0_ready", 32'(req_ready), 32'b001);
    tick();
    req_valid = '0;
    sample();
    chk("x0_wr_en", 32'(wr_en), 32'h0);
    chk("x0_grant_id", 32'(grant_id), 32'h0);
    chk("x0_wr_data", wr_data, 32'hdeadbeef);
    tick();
    drive(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h22);
    sample();
    chk("wrap_ready2", 32'(req_ready), 32'b100);
    tick();
    req_valid = '0;
    sample();
    chk("wrap_wr_addr", 32'(wr_addr), 32'h9);
    chk("wrap_grant_id", 32'(grant_id), 32'h2);
    tick();
    repeat (2) begin
      sample();
      chk("idle_wr_en", 32'(wr_en), 32'h0);
      tick();
    end
    drive(3'b101, 5'd3, 5'd0, 5'd4, 32'h33, 32'h0, 32'h44);
    sample();
    chk("hold_ready0", 32'(req_ready), 32'b001);
    tick();
    req_valid = 3'b100;
    sample();
    chk("hold_ready2", 32'(req_ready), 32'b100);
    chk("hold_wr_addr0", 32'(wr_addr), 32'h3);
    chk("hold_grant0", 32'(grant_id), 32'h0);
    tick();
    req_valid = '0;
    sample();
    chk("hold_wr_addr2", 32'(wr_addr), 32'h4);
    chk("hold_wr_data2", wr_data, 32'h44);
    chk("hold_grant2", 32'(grant_id), 32'h2);
    chk("hold_cnt", 32'(contention_cnt), 32'h1);
    tick();
    do_reset();
    drive(3'b011, 5'd10, 5'd11, 5'd0, 32'haa, 32'hbb, 32'h0);
    for (int k = 0; k <= 20; k++) begin
      sample();
      chk("sat_ready", 32'(req_ready), (k % 2 == 0) ? 32'b001 : 32'b010);
      chk("sat_cnt", 32'(contention_cnt), 32'((k < 15) ? k : 15));
      if (k > 0) chk("sat_wr_addr", 32'(wr_addr), (k % 2 == 1) ? 32'd10 : 32'd11);
      tick();
    end
    reset = 1'b1;
    sample();
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_cnt_held", 32'(contention_cnt), 32'hf);
    tick();
    reset = 1'b0;
    sample();
    chk("post_rst_wr_en", 32'(wr_en), 32'h0);
    chk("post_rst_cnt", 32'(contention_cnt), 32'h0);
    chk("post_rst_ptr", 32'(req_ready), 32'b001);
    tick();
    req_valid = 3'b010;
    sample();
    chk("post_rst_ready1", 32'(req_ready), 32'b010);
    chk("post_rst_cnt1", 32'(contention_cnt), 32'h1);
    chk("post_rst_wr_addr", 32'(wr_addr), 32'd10);
    tick();
    req_valid = '0;
    sample();
    chk("post_rst_wr_addr1", 32'(wr_addr), 32'd11);
    chk("post_rst_wr_en1", 32'(wr_en), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
